// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy encoding, statistics width,
// per-stage payload widths and the NOP payloads loaded on flush.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  localparam int unsigned PIPE_STAT_W = 16;

  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 128;
  localparam int unsigned EX_MEM_W = 96;
  localparam int unsigned MEM_WB_W = 72;

  // addi x0, x0, 0 in the instruction field keeps a flushed IF/ID slot decodable.
  localparam logic [31:0]         RV_NOP     = 32'h0000_0013;
  localparam logic [IF_ID_W-1:0]  IF_ID_NOP  = {32'h0000_0000, RV_NOP};
  localparam logic [ID_EX_W-1:0]  ID_EX_NOP  = '0;
  localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;
  localparam logic [MEM_WB_W-1:0] MEM_WB_NOP = '0;

  function automatic logic [1:0] occ_encode(input logic main_v, input logic skid_v);
    return skid_v ? OCC_FULL : (main_v ? OCC_ONE : OCC_EMPTY);
  endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module pipe_sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with 2-entry skid buffer, stall, flush and NOP fill.
// Optional statistics counters are enabled with PIPE_STAGE_STATS_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [PIPE_STAT_W-1:0] stall_cnt,
  output logic [PIPE_STAT_W-1:0] bubble_cnt,
  output logic [PIPE_STAT_W-1:0] flush_cnt
`endif
);

  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [1:0]        occ;
  logic              push, pop;

  assign occ       = occ_encode(main_valid_q, skid_valid_q);
  assign occupancy = occ;
  // stall is the only combinational term on either handshake side.
  assign in_ready  = !skid_valid_q && !stall;
  assign out_valid = main_valid_q && !stall;
  assign out_data  = main_data_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = FLUSH_VAL;
      skid_data_d  = FLUSH_VAL;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            main_data_d = in_data;
          end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
          end else if (pop) begin
            main_valid_d = 1'b0;
            main_data_d  = FLUSH_VAL;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            skid_valid_d = 1'b0;
            main_data_d  = skid_data_q;
            skid_data_d  = FLUSH_VAL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= FLUSH_VAL;
      skid_data_q  <= FLUSH_VAL;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_counter #(
    .Width(PIPE_STAT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .clr_i  (reset),
    .inc_i  (stall),
    .count_o(stall_cnt)
  );

  pipe_sat_counter #(
    .Width(PIPE_STAT_W)
  ) u_bubble_cnt (
    .clk_i  (clk),
    .clr_i  (reset),
    .inc_i  (out_ready && !out_valid && !stall),
    .count_o(bubble_cnt)
  );

  pipe_sat_counter #(
    .Width(PIPE_STAT_W)
  ) u_flush_cnt (
    .clk_i  (clk),
    .clr_i  (reset),
    .inc_i  (flush),
    .count_o(flush_cnt)
  );
`else
  // Statistics disabled: no counters, handshake behaviour unchanged.
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bus (control and data packed by the instantiating stage) with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Supports stall, flush, and bubble (NOP) injection with a programmable flush value.
- One instance sits between each pair of pipeline stages.

Parameters:
DATA_W, 64, payload width in bits (1..1024).
FLUSH_VAL, {DATA_W{1'b0}}, payload value loaded on reset, flush and drain (encodes the stage's NOP/bubble).

Ports:
clk  input  1  clock, all state on posedge.
reset  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
flush  input  1  synchronous squash of all held entries.
stall  input  1  freezes both handshake sides for this cycle.
in_valid  input  1  upstream payload valid.
in_ready  output  1  stage can accept upstream payload.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  downstream payload valid.
out_ready  input  1  downstream accepts payload.
out_data  output  DATA_W  downstream payload (main entry).
occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Storage: main entry (main_valid, main_data) drives out_data; skid entry (skid_valid, skid_data).
- in_ready = !skid_valid && !stall. The only combinational term is stall.
- out_valid = main_valid && !stall.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- States are encoded by occupancy: EMPTY=0, ONE=1, FULL=2.
  - EMPTY: push -> ONE, main_data<=in_data.
  - ONE: push&pop -> ONE, main_data<=in_data. push only -> FULL, skid_data<=in_data. pop only -> EMPTY, main_data<=FLUSH_VAL. Neither -> hold.
  - FULL: pop -> ONE, main_data<=skid_data, skid_data<=FLUSH_VAL. No pop -> hold; push impossible since in_ready=0.
- Latency: 1 cycle from push into EMPTY to out_valid. Sustained throughput 1 transfer/cycle when out_ready held high.
- Priority: reset > flush > stall > handshake.
- Reset or flush (sampled at posedge):
  - main_valid=skid_valid=0; main_data=skid_data=FLUSH_VAL; occupancy=0.
  - Next cycle: in_ready=1 (if stall=0), out_valid=0, out_data=FLUSH_VAL.
  - A push or pop coincident with flush is discarded; upstream must not count it as accepted.
- Stall: no push, no pop, all registers hold. Flush during stall still squashes.
- Payload registers are never X after reset; out_data equals FLUSH_VAL whenever occupancy=0.
- Reset mid-transfer: identical to flush, and also clears the optional counters.
- No data reordering: entries leave in arrival order. A skid entry never bypasses main.

Optional Feature:
PIPE_STAGE_STATS_EN
- Defined: adds outputs stall_cnt[15:0], bubble_cnt[15:0] and flush_cnt[15:0]. Each is a saturating counter (sticks at 16'hFFFF), reset to 0 by reset only (not by flush).
  - stall_cnt increments on cycles with stall=1.
  - bubble_cnt increments on cycles with out_ready=1 && out_valid=0 && stall=0.
  - flush_cnt increments on cycles with flush=1 && reset=0.
- Undefined: the ports and counters are absent; functional behaviour is identical.

Decomposition:
- Shared package pipe_pkg:
  - occupancy constants OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_FULL=2'd2.
  - PIPE_STAT_W=16.
  - Per-stage payload widths, and NOP payload constants used as FLUSH_VAL by stage instantiations.
- One sub-module: pipe_sat_counter (width param; inc, clr; saturating). Instantiated three times only under PIPE_STAGE_STATS_EN.

Test Plan:
- Stream: reset 2 cycles, then in_valid=1 with in_data=1,2,3,…,8 on consecutive cycles and out_ready=1 -> out_data 1..8 on consecutive cycles, each 1 cycle after push; occupancy stays 1; in_ready stays 1.
- Backpressure: push 0xA then 0xB with out_ready=0 -> occupancy 1 then 2, in_ready=0. Then raise out_ready -> 0xA then 0xB in order; in_ready returns 1 the cycle after 0xA pops.
- Flush at FULL: hold 0xA,0xB, assert flush while pushing 0xC -> next cycle occupancy=0, out_valid=0, out_data=FLUSH_VAL, 0xC never appears at the output.
- Stall: occupancy=1 with 0x5, stall=1 for 3 cycles with out_ready=1 and in_valid=1 -> in_ready=0, out_valid=0, no state change. Release -> 0x5 pops next cycle.
- Priority: assert reset and flush together with stall and push -> post-reset state. With PIPE_STAGE_STATS_EN, flush_cnt=0 after reset; after 3 solo flush cycles, flush_cnt=3.
- Saturation (PIPE_STAGE_STATS_EN): stall=1 for 65540 cycles -> stall_cnt=16'hFFFF and holds there.
